wishbone_board_ram_slave: RTL and testbench

Pipelined Wishbone responder fronting the Minesweeper board/tile RAM. It sits on the slave side of wishbone_arbiter and accepts requests from whichever master the arbiter has granted. It buffers accepted requests in a small FIFO, optionally inserts wait states, executes reads and writes on an internal synchronous RAM, and returns one ack per accepted request. It deasserts stall only while buffer space exists.

---
 rtl/wishbone_board_ram_slave_if.sv | 36 +++
 rtl/wishbone_board_ram_slave.sv | 153 +++++++++++++++
 tb/tb_wishbone_board_ram_slave.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_board_ram_slave_if.sv
// Wishbone bus bundle between the arbiter and the board/tile RAM responder.
// The wb_err_o line exists only when WB_SLAVE_ERR_EN is defined.
interface wishbone_board_ram_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_ack_o;
  logic                  wb_stall_o;
`ifdef WB_SLAVE_ERR_EN
  logic                  wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o, wb_err_o
  );
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_stall_o, wb_err_o
  );
`else
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );
`endif
endinterface

// File: rtl/wishbone_board_ram_slave.sv
// Pipelined Wishbone responder for the Minesweeper board RAM: request FIFO, optional wait
// states, in-order execution. Define WB_SLAVE_ERR_EN to signal out-of-range requests on wb_err_o.
module wishbone_board_ram_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 200,
  parameter int FIFO_DEPTH  = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  wishbone_board_ram_slave_if.slave  wb,
  output logic                       busy_o
);
  localparam int EW  = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC} state_t;

  logic [EW-1:0]         fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q  [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                  ack_q, busy_q, busy_d;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  stall, push, exec, in_range;
  logic [EW-1:0]         head;
  logic                  head_we;
  logic [ADDR_WIDTH-1:0] head_adr;
  logic [DATA_WIDTH-1:0] head_dat;
  logic [MAW-1:0]        ram_idx;
`ifdef WB_SLAVE_ERR_EN
  logic                  err_q;
  assign wb.wb_err_o = err_q;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Stall comes from the registered count only, so a same-edge pop never frees a slot early.
  assign stall    = (count_q == CW'(FIFO_DEPTH));
  assign push     = wb.wb_cyc_i && wb.wb_stb_i && !stall;
  assign head     = fifo_q[rd_ptr_q];
  assign head_we  = head[EW-1];
  assign head_adr = head[EW-2 -: ADDR_WIDTH];
  assign head_dat = head[DATA_WIDTH-1:0];
  assign ram_idx  = head_adr[MAW-1:0];
  assign in_range = (32'(head_adr) < 32'(DEPTH));

  assign wb.wb_stall_o = stall;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_dat_o   = dat_q;
  assign busy_o        = busy_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    exec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (WAIT_STATES == 0) begin
          exec = (count_q != '0);
        end else if ((count_q != '0) || push) begin
          // Countdown starts on the accepting edge so a lone request acks WAIT_STATES+1 edges later.
          state_d = S_WAIT;
          wait_d  = 4'(WAIT_STATES - 1);
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_EXEC;
        else              wait_d  = wait_q - 4'd1;
      end
      S_EXEC: begin
        exec    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!wb.wb_cyc_i) begin
      state_d = S_IDLE;
      wait_d  = '0;
      exec    = 1'b0;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (!wb.wb_cyc_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (exec) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !exec)      count_d = count_q + CW'(1);
      else if (!push && exec) count_d = count_q - CW'(1);
    end
    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {wb.wb_we_i, wb.wb_adr_i, wb.wb_dat_i};
  end

  always_ff @(posedge clk) begin
    if (exec && head_we && in_range) ram_q[ram_idx] <= head_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      busy_q   <= 1'b0;
`ifdef WB_SLAVE_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      busy_q   <= busy_d;
      ack_q    <= 1'b0;
`ifdef WB_SLAVE_ERR_EN
      err_q    <= 1'b0;
      if (exec) begin
        ack_q <= in_range;
        err_q <= !in_range;
        if (!head_we && in_range) dat_q <= ram_q[ram_idx];
      end
`else
      if (exec) begin
        ack_q <= 1'b1;
        if (!head_we) dat_q <= in_range ? ram_q[ram_idx] : '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_wishbone_board_ram_slave.sv
// Scoreboard bench for wishbone_board_ram_slave: one instance with WAIT_STATES=0, one with 3.
module tb_wishbone_board_ram_slave;
`ifdef WB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int          dut;
    logic        rd;
    logic [15:0] data;
    logic        err;
    int          exp_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc_r [2];
  logic        stb_r [2];
  logic        we_r  [2];
  logic [7:0]  adr_r [2];
  logic [15:0] dat_r [2];
  logic [1:0]  ack_w, err_w, stall_w, busy_w;
  logic [15:0] dato_w [2];

  exp_t        sb [$];
  exp_t        mon_e;
  logic [15:0] model [2][256];
  int          cyc_n = 0;
  int          stall_seen [2];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      wishbone_board_ram_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();
      assign bus.wb_cyc_i = cyc_r[gi];
      assign bus.wb_stb_i = stb_r[gi];
      assign bus.wb_we_i  = we_r[gi];
      assign bus.wb_adr_i = adr_r[gi];
      assign bus.wb_dat_i = dat_r[gi];
      assign ack_w[gi]    = bus.wb_ack_o;
      assign stall_w[gi]  = bus.wb_stall_o;
      assign dato_w[gi]   = bus.wb_dat_o;
`ifdef WB_SLAVE_ERR_EN
      assign err_w[gi]    = bus.wb_err_o;
`else
      assign err_w[gi]    = 1'b0;
`endif
      wishbone_board_ram_slave #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(200),
        .FIFO_DEPTH(2), .WAIT_STATES(gi * 3)
      ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wb     (bus),
        .busy_o (busy_w[gi])
      );
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Monitor: every ack/err pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (stall_w[k]) stall_seen[k]++;
        if (ack_w[k] || err_w[k]) begin
          if (sb.size() == 0) begin
            check_eq("spurious_ack", 32'd1, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            check_eq("ack_dut", k, mon_e.dut);
            check_eq("ack_kind", {30'd0, ack_w[k], err_w[k]}, {30'd0, !mon_e.err, mon_e.err});
            if (mon_e.rd && !mon_e.err) check_eq("rd_data", {16'd0, dato_w[k]}, {16'd0, mon_e.data});
            if (mon_e.exp_cyc >= 0) check_eq("ack_cycle", cyc_n, mon_e.exp_cyc);
            $display("[TB] dut%0d cycle %0d ack=%0b err=%0b rd=%0b dat=0x%04h", k, cyc_n,
                     ack_w[k], err_w[k], mon_e.rd, dato_w[k]);
          end
        end
      end
    end
  end

  // Caller is aligned just after a rising edge; returns aligned the same way.
  task automatic issue(input int k, input logic we, input logic [7:0] adr, input logic [15:0] dat,
                       input bit track, input int lat, output int acc);
    exp_t e;
    int   waits = 0;
    cyc_r[k] = 1'b1; stb_r[k] = 1'b1; we_r[k] = we; adr_r[k] = adr; dat_r[k] = dat;
    @(negedge clk);
    while (stall_w[k] && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (stall_w[k]) begin
      check_eq("accept_timeout", 32'd1, 32'd0);
      stb_r[k] = 1'b0;
      acc = -1;
      @(posedge clk); #1;
      return;
    end
    acc = cyc_n + 1;
    if (track) begin
      e.dut     = k;
      e.rd      = !we;
      e.err     = ERR_EN && (int'(adr) >= 200);
      e.data    = (int'(adr) < 200) ? model[k][adr] : 16'h0000;
      e.exp_cyc = (lat >= 0) ? acc + lat : -1;
      if (we && int'(adr) < 200) model[k][adr] = dat;
      sb.push_back(e);
    end
    $display("[TB] dut%0d cycle %0d accept we=%0b adr=0x%02h dat=0x%04h", k, acc, we, adr, dat);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int k);
    int w = 0;
    stb_r[k] = 1'b0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int a1, a2, a3, tmp;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, tmp;
    for (int k = 0; k < 2; k++) begin
      cyc_r[k] = 1'b0; stb_r[k] = 1'b0; we_r[k] = 1'b0; adr_r[k] = '0; dat_r[k] = '0;
      stall_seen[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_ack",   {31'd0, ack_w[k]},   32'd0);
      check_eq("rst_stall", {31'd0, stall_w[k]}, 32'd0);
      check_eq("rst_busy",  {31'd0, busy_w[k]},  32'd0);
      check_eq("rst_dat",   {16'd0, dato_w[k]},  32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write then read-back, zero wait states
    issue(0, 1'b1, 8'h10, 16'hA5A5, 1'b1, 1, tmp);
    issue(0, 1'b0, 8'h10, 16'h0000, 1'b1, 1, tmp);
    drain(0);

    // Back-to-back burst: no stall, contiguous acks
    stall_seen[0] = 0;
    for (int i = 0; i < 4; i++) issue(0, 1'b1, 8'(8'h20 + i), 16'((i + 1) * 16'h1111), 1'b1, 1, tmp);
    for (int i = 0; i < 4; i++) issue(0, 1'b0, 8'(8'h20 + i), 16'h0000, 1'b1, 1, tmp);
    drain(0);
    check_eq("burst_stall", stall_seen[0], 0);

    // Three requests into a two-deep FIFO with 3 wait states
    issue(1, 1'b1, 8'h40, 16'h0AAA, 1'b1, 4, a1);
    issue(1, 1'b1, 8'h41, 16'h0BBB, 1'b1, 8, a2);
    check_eq("stall_after_2", {31'd0, stall_w[1]}, 32'd1);
    check_eq("busy_queued",   {31'd0, busy_w[1]},  32'd1);
    issue(1, 1'b0, 8'h40, 16'h0000, 1'b1, 9, a3);
    check_eq("third_accept", a3, a1 + 5);
    drain(1);

    // Abort: queued writes are flushed with no ack, memory keeps prior contents
    issue(1, 1'b1, 8'h30, 16'h0101, 1'b1, 4, tmp);
    issue(1, 1'b1, 8'h31, 16'h0202, 1'b1, -1, tmp);
    drain(1);
    issue(1, 1'b1, 8'h30, 16'hBEEF, 1'b0, -1, tmp);
    issue(1, 1'b1, 8'h31, 16'hCAFE, 1'b0, -1, tmp);
    cyc_r[1] = 1'b0;
    stb_r[1] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_busy", {31'd0, busy_w[1]}, 32'd0);
    issue(1, 1'b0, 8'h30, 16'h0000, 1'b1, 4, tmp);
    issue(1, 1'b0, 8'h31, 16'h0000, 1'b1, 8, tmp);
    drain(1);

    // Out-of-range address
    issue(0, 1'b1, 8'hF0, 16'h1234, 1'b1, 1, tmp);
    issue(0, 1'b0, 8'hF0, 16'h0000, 1'b1, 1, tmp);
    drain(0);

    // Asynchronous reset with two requests queued
    issue(1, 1'b1, 8'h50, 16'h5555, 1'b0, -1, tmp);
    issue(1, 1'b0, 8'h50, 16'h0000, 1'b0, -1, tmp);
    stb_r[1] = 1'b0;
    #2;
    check_eq("pre_rst_stall", {31'd0, stall_w[1]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_ack",   {31'd0, ack_w[1]},   32'd0);
    check_eq("arst_stall", {31'd0, stall_w[1]}, 32'd0);
    check_eq("arst_busy",  {31'd0, busy_w[1]},  32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("post_rst_busy", {31'd0, busy_w[1]}, 32'd0);
    check_eq("post_rst_sb", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
